// File: rtl/ex_muldiv_if.sv
// EX-stage HI/LO arithmetic bundle: operands and forwarded HI/LO from ID/EX,
// stall request and HI/LO result back to the pipeline.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       aluop_i;
    logic [WIDTH-1:0] reg1_i;
    logic [WIDTH-1:0] reg2_i;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic             hold_i;
    logic             annul_i;
    logic             stallreq_o;
    logic             hilo_we_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    // Pipeline side: presents the instruction and consumes the result.
    modport master (
        output aluop_i, reg1_i, reg2_i, hi_i, lo_i, hold_i, annul_i,
        input  stallreq_o, hilo_we_o, hi_o, lo_o
    );

    // Arithmetic unit side.
    modport slave (
        input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, hold_i, annul_i,
        output stallreq_o, hilo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle HI/LO unit for the EX stage: restoring DIV/DIVU (one bit per cycle)
// and MADD/MADDU/MSUB/MSUBU accumulating into the forwarded HI/LO pair.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_if.slave      bus
);
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        DIV_ON,
        DIV_END,
        DIV_ZERO,
        MAC_ACC
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;        // dividend, shifted out MSB-first; quotient shifts in at LSB
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;
    logic [2*WIDTH-1:0] prod;
    logic             mac_sub;

    logic             op_div_any;
    logic             op_div_signed;
    logic             op_mac_any;
    logic             op_mac_signed;
    logic             op_mac_sub;
    logic             div_by_zero;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_shift;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] acc;

    logic             stallreq;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Opcode decode and datapath helpers.
    always_comb begin
        op_div_signed = (bus.aluop_i == OP_DIV);
        op_div_any    = op_div_signed || (bus.aluop_i == OP_DIVU);
        op_mac_signed = (bus.aluop_i == OP_MADD) || (bus.aluop_i == OP_MSUB);
        op_mac_sub    = (bus.aluop_i == OP_MSUB) || (bus.aluop_i == OP_MSUBU);
        op_mac_any    = op_mac_signed || (bus.aluop_i == OP_MADDU) || (bus.aluop_i == OP_MSUBU);
        div_by_zero   = (bus.reg2_i == '0);

        // Restoring step: trial subtract from the partial remainder with the next dividend bit.
        diff      = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dsr};
        borrow    = diff[WIDTH+1];
        rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]};

        // Operands extended to 2*WIDTH so the low half of the product is exact for both signednesses.
        if (op_mac_signed) begin
            prod_next = {{WIDTH{bus.reg1_i[WIDTH-1]}}, bus.reg1_i}
                      * {{WIDTH{bus.reg2_i[WIDTH-1]}}, bus.reg2_i};
        end else begin
            prod_next = {{WIDTH{1'b0}}, bus.reg1_i} * {{WIDTH{1'b0}}, bus.reg2_i};
        end

        acc = mac_sub ? ({bus.hi_i, bus.lo_i} - prod) : ({bus.hi_i, bus.lo_i} + prod);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (rst || bus.annul_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        state_n  = state;
        stallreq = 1'b0;
        hilo_we  = 1'b0;
        hi       = '0;
        lo       = '0;

        unique case (state)
            IDLE: begin
                if (op_div_any) begin
                    stallreq = 1'b1;
                    state_n  = div_by_zero ? DIV_ZERO : DIV_ON;
                end else if (op_mac_any) begin
                    stallreq = 1'b1;
                    state_n  = MAC_ACC;
                end
            end
            DIV_ON: begin
                stallreq = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_n = DIV_END;
                end
            end
            DIV_END: begin
                hilo_we = 1'b1;
                lo      = neg_q ? -dvd : dvd;
                hi      = neg_r ? -rem : rem;
                if (!bus.hold_i) begin
                    state_n = IDLE;
                end
            end
            DIV_ZERO: begin
                hilo_we = 1'b1;
                if (!bus.hold_i) begin
                    state_n = IDLE;
                end
            end
            MAC_ACC: begin
                hilo_we  = 1'b1;
                {hi, lo} = acc;
                if (!bus.hold_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A flushed instruction must never commit to HI/LO.
        if (bus.annul_i) begin
            hilo_we = 1'b0;
        end
    end

    // Divider and accumulator datapath registers.
    always_ff @(posedge clk) begin
        if (rst || bus.annul_i) begin
            cnt     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            prod    <= '0;
            mac_sub <= 1'b0;
        end else if (state == IDLE) begin
            if (op_div_any && !div_by_zero) begin
                dvd   <= (op_div_signed && bus.reg1_i[WIDTH-1]) ? -bus.reg1_i : bus.reg1_i;
                dsr   <= (op_div_signed && bus.reg2_i[WIDTH-1]) ? -bus.reg2_i : bus.reg2_i;
                rem   <= '0;
                cnt   <= '0;
                neg_q <= op_div_signed && (bus.reg1_i[WIDTH-1] ^ bus.reg2_i[WIDTH-1]);
                neg_r <= op_div_signed && bus.reg1_i[WIDTH-1];
            end else if (op_mac_any) begin
                prod    <= prod_next;
                mac_sub <= op_mac_sub;
            end
        end else if (state == DIV_ON) begin
            dvd <= {dvd[WIDTH-2:0], ~borrow};
            rem <= borrow ? rem_shift : diff[WIDTH-1:0];
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.stallreq_o = stallreq;
    assign bus.hilo_we_o  = hilo_we;
    assign bus.hi_o       = hi;
    assign bus.lo_o       = lo;

endmodule
